// File: rtl/pic_acknowledge_sequencer.sv
// 8259A interrupt-acknowledge sequencer (8086 mode): drives INT, tracks the two INTA# pulses,
// owns the in-service register and priority rotation, and handles EOI / set-priority commands.
module pic_acknowledge_sequencer #(
    parameter logic [2:0]  RESET_PRIORITY_ROTATE = 3'b111,
    parameter int unsigned ACK_TIMEOUT           = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       interrupt_acknowledge_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi_config,
    input  logic       auto_rotate_config,
    input  logic       end_of_interrupt,
    input  logic       specific_eoi,
    input  logic       rotate_on_eoi,
    input  logic [2:0] eoi_level,
    input  logic       set_priority,
    input  logic [2:0] set_priority_level,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] data_out,
    output logic       data_out_enable,
    output logic       ack_timeout
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {IDLE, PENDING, ACK1, WAIT2, ACK2} state_t;

    state_t             state, state_next;
    logic               inta_prev;
    logic               fall, rise;
    logic [CNT_W-1:0]   count, count_next;
    logic [2:0]         level, level_next;
    logic               spurious, spurious_next;
    logic               int_next, doe_next, tmo_next;
    logic [7:0]         isr_next, clr_next, dout_next;
    logic [7:0]         set_mask, clear_mask;
    logic [2:0]         rot_next;
    logic               take_first;
    logic               found;
    logic [2:0]         scan_idx;

    function automatic logic [2:0] encode(input logic [7:0] onehot);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign fall = inta_prev & ~interrupt_acknowledge_n;
    assign rise = ~inta_prev & interrupt_acknowledge_n;

    // Rotating priority scan: starts just above the lowest-priority level and wraps.
    always_comb begin
        highest_level_in_service = 8'd0;
        found    = 1'b0;
        scan_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = 3'(priority_rotate + 3'(i) + 3'd1);
            if (!found && in_service_register[scan_idx]) begin
                highest_level_in_service[scan_idx] = 1'b1;
                found = 1'b1;
            end
        end
    end

    // Next-state, ISR update and registered-output next values.
    always_comb begin
        state_next    = state;
        int_next      = int_out;
        clr_next      = 8'd0;
        tmo_next      = 1'b0;
        dout_next     = data_out;
        doe_next      = data_out_enable;
        count_next    = count;
        level_next    = level;
        spurious_next = spurious;
        set_mask      = 8'd0;
        clear_mask    = 8'd0;
        rot_next      = priority_rotate;
        take_first    = 1'b0;

        case (state)
            IDLE: begin
                if (fall) begin
                    take_first = 1'b1;
                end else if (interrupt != 8'd0) begin
                    state_next = PENDING;
                    int_next   = 1'b1;
                end
            end
            PENDING: begin
                if (fall) begin
                    take_first = 1'b1;
                end else if (interrupt == 8'd0) begin
                    state_next = IDLE;
                    int_next   = 1'b0;
                end
            end
            ACK1: begin
                doe_next = 1'b0;
                if (rise) begin
                    state_next = WAIT2;
                    count_next = '0;
                end
            end
            WAIT2: begin
                count_next = count + CNT_W'(1);
                if (fall) begin
                    state_next = ACK2;
                    doe_next   = 1'b1;
                    dout_next  = {vector_base, level};
                end else if (count_next == CNT_W'(ACK_TIMEOUT)) begin
                    state_next = IDLE;
                    tmo_next   = 1'b1;
                    count_next = '0;
                end
            end
            ACK2: begin
                doe_next  = 1'b1;
                dout_next = {vector_base, level};
                if (rise) begin
                    state_next = IDLE;
                    doe_next   = 1'b0;
                    if (auto_eoi_config && !spurious) begin
                        clear_mask[level] = 1'b1;
                        if (auto_rotate_config) rot_next = level;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // First INTA# fall: from IDLE too, so a fall coincident with a new request is not lost.
        if (take_first) begin
            state_next = ACK1;
            int_next   = 1'b0;
            doe_next   = 1'b0;
            if (interrupt != 8'd0) begin
                level_next    = encode(interrupt);
                set_mask      = interrupt;
                clr_next      = interrupt;
                spurious_next = 1'b0;
            end else begin
                level_next    = 3'd7;
                spurious_next = 1'b1;
            end
        end

        if (end_of_interrupt && (highest_level_in_service != 8'd0)) begin
            clear_mask = clear_mask | highest_level_in_service;
            if (rotate_on_eoi) rot_next = encode(highest_level_in_service);
        end
        if (specific_eoi) begin
            clear_mask[eoi_level] = 1'b1;
            if (rotate_on_eoi) rot_next = eoi_level;
        end
        if (set_priority) rot_next = set_priority_level;

        // Clear before set so a same-bit conflict leaves the bit set.
        isr_next = (in_service_register & ~clear_mask) | set_mask;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            inta_prev               <= 1'b1;
            count                   <= '0;
            level                   <= 3'd0;
            spurious                <= 1'b0;
            int_out                 <= 1'b0;
            in_service_register     <= 8'd0;
            priority_rotate         <= RESET_PRIORITY_ROTATE;
            clear_interrupt_request <= 8'd0;
            data_out                <= 8'd0;
            data_out_enable         <= 1'b0;
            ack_timeout             <= 1'b0;
        end else begin
            state                   <= state_next;
            inta_prev               <= interrupt_acknowledge_n;
            count                   <= count_next;
            level                   <= level_next;
            spurious                <= spurious_next;
            int_out                 <= int_next;
            in_service_register     <= isr_next;
            priority_rotate         <= rot_next;
            clear_interrupt_request <= clr_next;
            data_out                <= dout_next;
            data_out_enable         <= doe_next;
            ack_timeout             <= tmo_next;
        end
    end

endmodule

// File: tb/tb_pic_acknowledge_sequencer.sv
// Directed self-checking bench for pic_acknowledge_sequencer.
module tb_pic_acknowledge_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] interrupt;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi_config, auto_rotate_config;
    logic       end_of_interrupt, specific_eoi, rotate_on_eoi;
    logic [2:0] eoi_level;
    logic       set_priority;
    logic [2:0] set_priority_level;
    logic       int_out;
    logic [7:0] isr, highest, clr, data_out;
    logic [2:0] rotate;
    logic       doe, ack_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    pic_acknowledge_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .interrupt                (interrupt),
        .interrupt_acknowledge_n  (inta_n),
        .vector_base              (vector_base),
        .auto_eoi_config          (auto_eoi_config),
        .auto_rotate_config       (auto_rotate_config),
        .end_of_interrupt         (end_of_interrupt),
        .specific_eoi             (specific_eoi),
        .rotate_on_eoi            (rotate_on_eoi),
        .eoi_level                (eoi_level),
        .set_priority             (set_priority),
        .set_priority_level       (set_priority_level),
        .int_out                  (int_out),
        .in_service_register      (isr),
        .highest_level_in_service (highest),
        .priority_rotate          (rotate),
        .clear_interrupt_request  (clr),
        .data_out                 (data_out),
        .data_out_enable          (doe),
        .ack_timeout              (ack_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full two-pulse acknowledge of one request, starting and ending in IDLE.
    task automatic do_ack(input logic [7:0] irq);
        interrupt = irq; tick();
        inta_n = 1'b0;   tick();
        interrupt = 8'd0; tick();
        inta_n = 1'b1;   tick();
        inta_n = 1'b0;   tick();
        inta_n = 1'b1;   tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        n_cmp++; if (int_out !== 1'b0)   begin n_fail++; $display("FAIL reset_int got=%b want=0", int_out); end
        n_cmp++; if (isr !== 8'h00)      begin n_fail++; $display("FAIL reset_isr got=%h want=00", isr); end
        n_cmp++; if (rotate !== 3'd7)    begin n_fail++; $display("FAIL reset_rotate got=%0d want=7", rotate); end
        n_cmp++; if (doe !== 1'b0)       begin n_fail++; $display("FAIL reset_doe got=%b want=0", doe); end
        n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h want=00", data_out); end
        n_cmp++; if (clr !== 8'h00 || ack_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%h/%b want=00/0", clr, ack_timeout); end
    endtask

    task automatic test_basic_ack();
        vector_base = 5'b01000;
        interrupt = 8'b0000_0100; tick();
        n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL basic_int_raise got=%b want=1", int_out); end
        inta_n = 1'b0; tick();
        n_cmp++; if (isr !== 8'h04) begin n_fail++; $display("FAIL basic_isr got=%h want=04", isr); end
        n_cmp++; if (clr !== 8'h04) begin n_fail++; $display("FAIL basic_clr got=%h want=04", clr); end
        n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL basic_int_drop got=%b want=0", int_out); end
        interrupt = 8'd0; tick();
        n_cmp++; if (clr !== 8'h00) begin n_fail++; $display("FAIL basic_clr_oneshot got=%h want=00", clr); end
        inta_n = 1'b1; tick();
        n_cmp++; if (doe !== 1'b0) begin n_fail++; $display("FAIL basic_doe_between got=%b want=0", doe); end
        inta_n = 1'b0; tick();
        n_cmp++; if (doe !== 1'b1 || data_out !== 8'h42) begin n_fail++; $display("FAIL basic_vector got=%b/%h want=1/42", doe, data_out); end
        tick();
        n_cmp++; if (doe !== 1'b1) begin n_fail++; $display("FAIL basic_doe_hold got=%b want=1", doe); end
        inta_n = 1'b1; tick();
        n_cmp++; if (doe !== 1'b0) begin n_fail++; $display("FAIL basic_doe_release got=%b want=0", doe); end
        n_cmp++; if (isr !== 8'h04) begin n_fail++; $display("FAIL basic_isr_kept got=%h want=04", isr); end
    endtask

    task automatic test_set_clear_conflict();
        interrupt = 8'b0000_0100; tick();
        inta_n = 1'b0; specific_eoi = 1'b1; eoi_level = 3'd2; tick();
        specific_eoi = 1'b0;
        n_cmp++; if (isr !== 8'h04) begin n_fail++; $display("FAIL conflict_isr got=%h want=04", isr); end
        interrupt = 8'd0; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        specific_eoi = 1'b1; eoi_level = 3'd2; tick(); specific_eoi = 1'b0;
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL conflict_cleanup got=%h want=00", isr); end
    endtask

    task automatic test_auto_eoi();
        auto_eoi_config = 1'b1; auto_rotate_config = 1'b1;
        do_ack(8'b0010_0000);
        n_cmp++; if (isr !== 8'h00)  begin n_fail++; $display("FAIL aeoi_isr got=%h want=00", isr); end
        n_cmp++; if (rotate !== 3'd5) begin n_fail++; $display("FAIL aeoi_rotate got=%0d want=5", rotate); end
        auto_eoi_config = 1'b0; auto_rotate_config = 1'b0;
        set_priority = 1'b1; set_priority_level = 3'd7; tick(); set_priority = 1'b0;
        n_cmp++; if (rotate !== 3'd7) begin n_fail++; $display("FAIL setprio_restore got=%0d want=7", rotate); end
    endtask

    task automatic test_eoi();
        do_ack(8'b0000_0010);
        do_ack(8'b0000_1000);
        n_cmp++; if (isr !== 8'h0A)     begin n_fail++; $display("FAIL eoi_isr_setup got=%h want=0a", isr); end
        n_cmp++; if (highest !== 8'h02) begin n_fail++; $display("FAIL eoi_highest got=%h want=02", highest); end
        end_of_interrupt = 1'b1; tick(); end_of_interrupt = 1'b0;
        n_cmp++; if (isr !== 8'h08)     begin n_fail++; $display("FAIL eoi_nonspec got=%h want=08", isr); end
        n_cmp++; if (rotate !== 3'd7)   begin n_fail++; $display("FAIL eoi_no_rotate got=%0d want=7", rotate); end
        specific_eoi = 1'b1; eoi_level = 3'd3; tick(); specific_eoi = 1'b0;
        n_cmp++; if (isr !== 8'h00 || highest !== 8'h00) begin n_fail++; $display("FAIL eoi_specific got=%h/%h want=00/00", isr, highest); end
        end_of_interrupt = 1'b1; rotate_on_eoi = 1'b1; tick(); end_of_interrupt = 1'b0; rotate_on_eoi = 1'b0;
        n_cmp++; if (rotate !== 3'd7)   begin n_fail++; $display("FAIL eoi_empty_rotate got=%0d want=7", rotate); end
    endtask

    task automatic test_set_priority();
        do_ack(8'b0001_0000);
        set_priority = 1'b1; set_priority_level = 3'd2; end_of_interrupt = 1'b1; rotate_on_eoi = 1'b1; tick();
        set_priority = 1'b0; end_of_interrupt = 1'b0; rotate_on_eoi = 1'b0;
        n_cmp++; if (isr !== 8'h00 || rotate !== 3'd2) begin n_fail++; $display("FAIL setprio_wins got=%h/%0d want=00/2", isr, rotate); end
        do_ack(8'b0000_0001);
        do_ack(8'b0001_0000);
        n_cmp++; if (highest !== 8'h10) begin n_fail++; $display("FAIL rotated_highest got=%h want=10", highest); end
        end_of_interrupt = 1'b1; rotate_on_eoi = 1'b1; tick(); end_of_interrupt = 1'b0; rotate_on_eoi = 1'b0;
        n_cmp++; if (isr !== 8'h01 || rotate !== 3'd4) begin n_fail++; $display("FAIL eoi_rotate got=%h/%0d want=01/4", isr, rotate); end
        specific_eoi = 1'b1; eoi_level = 3'd0; set_priority = 1'b1; set_priority_level = 3'd7; tick();
        specific_eoi = 1'b0; set_priority = 1'b0;
    endtask

    task automatic test_withdraw_and_spurious();
        interrupt = 8'b0000_1000; tick();
        n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL withdraw_raise got=%b want=1", int_out); end
        interrupt = 8'd0; tick();
        n_cmp++; if (int_out !== 1'b0 || clr !== 8'h00) begin n_fail++; $display("FAIL withdraw got=%b/%h want=0/00", int_out, clr); end
        vector_base = 5'b01000;
        inta_n = 1'b0; tick();
        n_cmp++; if (isr !== 8'h00 || clr !== 8'h00) begin n_fail++; $display("FAIL spurious_noset got=%h/%h want=00/00", isr, clr); end
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        n_cmp++; if (data_out !== 8'h47 || doe !== 1'b1) begin n_fail++; $display("FAIL spurious_vector got=%h/%b want=47/1", data_out, doe); end
        inta_n = 1'b1; tick();
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL spurious_isr got=%h want=00", isr); end
    endtask

    task automatic test_same_cycle_fall();
        interrupt = 8'b0100_0000; inta_n = 1'b0; tick();
        n_cmp++; if (isr !== 8'h40 || clr !== 8'h40 || int_out !== 1'b0) begin n_fail++; $display("FAIL idle_fall got=%h/%h/%b want=40/40/0", isr, clr, int_out); end
        interrupt = 8'd0; tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        n_cmp++; if (data_out !== 8'h46) begin n_fail++; $display("FAIL idle_fall_vector got=%h want=46", data_out); end
        inta_n = 1'b1; tick();
        specific_eoi = 1'b1; eoi_level = 3'd6; tick(); specific_eoi = 1'b0;
    endtask

    task automatic test_timeout();
        bit early = 1'b0;
        interrupt = 8'b0000_0010; tick();
        inta_n = 1'b0; tick();
        interrupt = 8'd0; inta_n = 1'b1; tick();
        for (int i = 0; i < 254; i++) begin
            tick();
            if (ack_timeout !== 1'b0) early = 1'b1;
        end
        n_cmp++; if (early) begin n_fail++; $display("FAIL timeout_early got=1 want=0"); end
        tick();
        n_cmp++; if (ack_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse got=%b want=1", ack_timeout); end
        interrupt = 8'b0000_0100; tick();
        n_cmp++; if (ack_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_oneshot got=%b want=0", ack_timeout); end
        n_cmp++; if (isr !== 8'h02) begin n_fail++; $display("FAIL timeout_isr_kept got=%h want=02", isr); end
        n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL timeout_idle got=%b want=1", int_out); end
        interrupt = 8'd0; tick();
        specific_eoi = 1'b1; eoi_level = 3'd1; tick(); specific_eoi = 1'b0;
    endtask

    task automatic test_reset_in_ack2();
        set_priority = 1'b1; set_priority_level = 3'd3; tick(); set_priority = 1'b0;
        interrupt = 8'b0000_0001; tick();
        inta_n = 1'b0; tick();
        interrupt = 8'd0; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        n_cmp++; if (doe !== 1'b1) begin n_fail++; $display("FAIL ack2_reach got=%b want=1", doe); end
        reset = 1'b1; tick();
        n_cmp++; if (isr !== 8'h00 || doe !== 1'b0 || data_out !== 8'h00 || int_out !== 1'b0 || clr !== 8'h00 || rotate !== 3'd7)
            begin n_fail++; $display("FAIL ack2_reset got=%h/%b/%h/%b/%h/%0d want=00/0/00/0/00/7", isr, doe, data_out, int_out, clr, rotate); end
        reset = 1'b0; inta_n = 1'b1; tick();
        n_cmp++; if (doe !== 1'b0 || isr !== 8'h00) begin n_fail++; $display("FAIL post_reset got=%b/%h want=0/00", doe, isr); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; interrupt = 8'd0; inta_n = 1'b1; vector_base = 5'd0;
        auto_eoi_config = 1'b0; auto_rotate_config = 1'b0;
        end_of_interrupt = 1'b0; specific_eoi = 1'b0; rotate_on_eoi = 1'b0; eoi_level = 3'd0;
        set_priority = 1'b0; set_priority_level = 3'd0;
        #2;
        test_reset();
        test_basic_ack();
        test_set_clear_conflict();
        test_auto_eoi();
        test_eoi();
        test_set_priority();
        test_withdraw_and_spurious();
        test_same_cycle_fall();
        test_timeout();
        test_reset_in_ack2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_acknowledge_sequencer.md
Name: pic_acknowledge_sequencer

Overview:
Control block that sequences the 8259A priority resolver through the 8086-mode interrupt acknowledge cycle. It raises INT from the resolver's one-hot winner and tracks two INTA# pulses. It sets the in-service register, strobes the IRR bit clear, drives the vector byte, and processes EOI, rotation and set-priority commands. It owns in_service_register, highest_level_in_service and priority_rotate, which feed back into the resolver.

Parameters:
RESET_PRIORITY_ROTATE, 3'b111, priority_rotate value after reset (IR0 highest).
ACK_TIMEOUT, 255, maximum cycles between end of first and start of second INTA# pulse before abort; range 1..255.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
interrupt  in  8  one-hot winning request from priority resolver (0 = none)
interrupt_acknowledge_n  in  1  INTA#, already synchronised to clock, active low
vector_base  in  5  ICW2 T7..T3
auto_eoi_config  in  1  AEOI mode
auto_rotate_config  in  1  rotate priority on AEOI
end_of_interrupt  in  1  one-cycle non-specific EOI command
specific_eoi  in  1  one-cycle specific EOI command
rotate_on_eoi  in  1  qualifier for either EOI command: also rotate priority
eoi_level  in  3  level for specific_eoi
set_priority  in  1  one-cycle set-priority command
set_priority_level  in  3  new lowest-priority level
int_out  out  1  INT to CPU
in_service_register  out  8  ISR
highest_level_in_service  out  8  one-hot highest-priority set ISR bit (0 if ISR = 0)
priority_rotate  out  3  current lowest-priority level
clear_interrupt_request  out  8  one-cycle strobe clearing the IRR bit
data_out  out  8  vector byte
data_out_enable  out  1  bus drive enable for data_out
ack_timeout  out  1  one-cycle pulse on aborted acknowledge

Behaviour:
- Reset: all outputs 0, except priority_rotate = RESET_PRIORITY_ROTATE; FSM to IDLE; timeout counter 0; INTA# edge register set to 1. Reset mid-sequence aborts with no strobes.
- INTA# edges come from a registered copy. Fall = prev 1 & now 0. Rise = prev 0 & now 1.
- FSM states: IDLE, PENDING, ACK1, WAIT2, ACK2.
- IDLE: interrupt != 0 -> PENDING. int_out = 1 from the next cycle (registered).
- PENDING: interrupt == 0 before a fall -> IDLE, int_out = 0 (withdrawn request).
  - On fall: latch level = encode(interrupt); ISR |= interrupt; clear_interrupt_request = interrupt for 1 cycle; int_out = 0; -> ACK1.
  - A fall with interrupt == 0 is spurious: latch level 7, no ISR/IRR change.
- ACK1: data_out_enable = 0; on rise -> WAIT2, counter = 0.
- WAIT2: counter increments each cycle; on fall -> ACK2.
  - Counter reaches ACK_TIMEOUT -> IDLE, pulse ack_timeout; the ISR bit stays set.
- ACK2: data_out = {vector_base, level}, data_out_enable = 1 while in ACK2 (registered, from the cycle after the fall). On rise -> IDLE, data_out_enable = 0.
  - If auto_eoi_config and not spurious: clear ISR[level] on that rise.
  - If auto_rotate_config is also set: priority_rotate = level.
- A fall seen in IDLE or WAIT2 start is never lost: IDLE with interrupt != 0 and fall in the same cycle behaves as PENDING+fall.
- highest_level_in_service: combinational from registered ISR and priority_rotate. Scan order starts at priority_rotate+1 (mod 8) and ends at priority_rotate.
- Non-specific EOI clears the bit in highest_level_in_service. No-op if ISR = 0.
- Specific EOI clears ISR[eoi_level].
- rotate_on_eoi with either EOI: priority_rotate = cleared level. For non-specific with ISR = 0, no rotation.
- set_priority: priority_rotate = set_priority_level. If set_priority and an EOI rotation occur in the same cycle, set_priority wins.
- Same-cycle ISR set (first INTA) and EOI clear: apply the clear first, then the set; a same-bit conflict leaves the bit set.
- EOI commands are accepted in every state.
- Vector arithmetic: low 3 bits replaced by level; no carry.

Test Plan:
- Reset, then interrupt = 8'b00000100, vector_base = 5'b01000 -> int_out = 1 next cycle. INTA# fall -> ISR = 8'b00000100, clear_interrupt_request = 8'b00000100 for 1 cycle, int_out = 0. Second pulse -> data_out = 8'h42, data_out_enable = 1 only during pulse.
- auto_eoi_config = 1, auto_rotate_config = 1, interrupt = 8'b00100000 -> after second INTA# rise, ISR = 0 and priority_rotate = 3'd5.
- ISR = 8'b00001010, priority_rotate = 3'b111 -> highest_level_in_service = 8'b00000010. end_of_interrupt -> ISR = 8'b00001000. specific_eoi with eoi_level = 3 -> ISR = 0.
- interrupt goes to 0 in PENDING -> int_out = 0 with no strobe. A separate first INTA# fall with interrupt = 0 -> spurious: ISR unchanged, data_out = {vector_base, 3'd7}.
- After first pulse hold INTA# high for ACK_TIMEOUT cycles -> ack_timeout pulse, FSM in IDLE, ISR bit kept. Reset asserted in ACK2 -> all outputs at reset values next cycle.
- set_priority with level 3'd2 in the same cycle as end_of_interrupt + rotate_on_eoi (ISR = 8'b00010000) -> ISR = 0, priority_rotate = 3'd2.
